eth_manchester_tx: RTL
======================

# eth_manchester_tx

Ethernet-side transmit framer and Manchester encoder: accepts a byte stream on a valid/ready handshake and drives a 10 Mb/s Manchester line at 100 MHz. Each frame is sent as:

- 7 preamble bytes of 0xAA,
- one SFD byte of 0xAB,
- the payload bytes,
- an idle-high interframe gap.

It is the outbound counterpart of the Ethernet Manchester receive path in the USB–Ethernet bridge. It lets the bridge return USB-host data onto the Ethernet wire.

## Interface
Parameters:
- HALF_BIT_CYCLES, 5, clocks per Manchester half-bit (10 clocks per bit).
- PREAMBLE_BYTES, 7, count of 0xAA bytes before the SFD.
- IFG_CYCLES, 20, minimum idle-high clocks after each frame.

Ports:
- clk  input  1  single clock, 100 MHz Ethernet domain.
- rst  input  1  synchronous reset, active-high.
- tx_data  input  8  payload byte.
- tx_valid  input  1  tx_data is valid; in IDLE this also requests a frame.
- tx_last  input  1  qualifies tx_data as the final payload byte.
- tx_ready  output  1  one-cycle pulse; the byte is accepted on that clock edge.
- eth_out  output  1  Manchester line, registered, idle high.
- busy  output  1  high in every state except IDLE.
- underrun  output  1  one-cycle pulse when a payload byte is missing at a byte boundary.

## Operation
- **Reset:**
  - Outputs: eth_out=1, tx_ready=0, busy=0, underrun=0.
  - Internal: state=IDLE, all counters 0.
  - rst has priority over every other event; reset mid-frame drives eth_out=1 on the next cycle, and the frame is dropped.
- **Encoding:** bits are sent MSB first.
  - Bit 1 is sent as low half then high half.
  - Bit 0 is sent as high half then low half.
  - Each byte is 16 half-bits of HALF_BIT_CYCLES clocks, i.e. 80 clocks.
- **States:** IDLE, PREAMBLE, SFD, DATA, IFG.
- **IDLE:**
  - eth_out=1.
  - tx_valid=1 starts a frame: load 0xAA, go to PREAMBLE. No byte is consumed.
- **PREAMBLE:**
  - Sends PREAMBLE_BYTES copies of 0xAA.
  - A byte counter (3 bits, counting 0..PREAMBLE_BYTES-1) advances at each byte boundary.
  - After the last copy, load 0xAB and go to SFD.
- **Byte boundary:** the last clock of half-bit 15 of the current byte.
- **SFD, DATA not-last, at a boundary:**
  - If tx_valid=1: pulse tx_ready, capture tx_data and tx_last, go to or stay in DATA.
  - If tx_valid=0: pulse underrun, go to IFG (frame is truncated).
- **DATA last byte at its boundary:** no tx_ready; go to IFG.
- **IFG:**
  - eth_out=1 for exactly IFG_CYCLES clocks, then go to IDLE.
  - tx_valid is ignored; tx_ready stays 0.
- **Outside byte boundaries:** tx_ready=0. tx_data, tx_valid and tx_last are don't-care.
- **Counters:**
  - Half-bit cycle counter: 0..HALF_BIT_CYCLES-1, wraps.
  - Half index: 4 bits, 0..15, wraps at the byte boundary.
  - IFG counter: width $clog2(IFG_CYCLES+1).

## Timing
- A frame is requested by tx_valid in IDLE at edge N.
- eth_out shows the first preamble half-bit (low) from cycle N+1.
- The SFD starts at N+1+80·PREAMBLE_BYTES, i.e. N+561.
- The first tx_ready pulse falls on the last SFD clock, N+640. Byte 0 appears on eth_out at N+641.
- Back-to-back payload: one tx_ready every 80 clocks. There are no gaps on the line between bytes.
- After the last byte's final half-bit, eth_out=1 for IFG_CYCLES clocks. The earliest next frame request is accepted on the first IDLE cycle after that.
- busy rises the cycle after the request edge and falls the cycle after IFG completes.
- eth_out and the half-bit transitions come from registers; there is no combinational path from inputs to eth_out.

## Structure
- Package eth_tx_pkg holds:
  - the state enum (IDLE, PREAMBLE, SFD, DATA, IFG);
  - PREAMBLE_BYTE = 8'hAA and SFD_BYTE = 8'hAB;
  - the Manchester half-bit encoding constants (1 = 01, 0 = 10).
- Sub-module manchester_half_timer:
  - Parameter HALF_BIT_CYCLES.
  - Inputs clk, rst, en.
  - Outputs half_tick (last clock of a half-bit) and byte_tick (half_tick on half index 15).
  - The FSM and shift register live in eth_manchester_tx.

## Test plan
- **Reset idle:** assert rst for 2 cycles, then hold tx_valid=0 for 200 cycles -> eth_out=1, busy=0, no tx_ready or underrun.
- **Preamble/SFD:** request a one-byte frame 0x0F with tx_last=1 -> decoded line is 7×0xAA then 0xAB then 0x0F. Decode by sampling at 2.5 and 7.5 clocks into each bit. Exactly one tx_ready at request+640. eth_out=1 for 20 clocks after the final half-bit.
- **Multi-byte:** stream 0xFB×14 then 0xF0 with last -> 15 tx_ready pulses exactly 80 clocks apart, all bytes decode correctly, no idle between bytes.
- **Underrun:** after 2 payload bytes, drop tx_valid at the third boundary -> underrun pulses once, the line goes high for IFG_CYCLES, then IDLE.
- **Reset mid-frame:** assert rst during the SFD -> eth_out=1 the next cycle, busy=0. A new request afterwards restarts a full preamble.
- **Back-to-back frames:** hold tx_valid high through the IFG -> no tx_ready during the IFG. The next preamble starts the cycle after IDLE is entered; the line is high for at least 20 clocks between frames.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet Manchester transmit framer.
// Holds the frame states, the fixed preamble/SFD bytes and the Manchester line codes.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    IFG
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE      = 8'hAB;

  // Line codes are {first half, second half}: a 1 rises mid-bit, a 0 falls mid-bit.
  localparam logic [1:0] MANCH_ONE  = 2'b01;
  localparam logic [1:0] MANCH_ZERO = 2'b10;

  function automatic logic manch_level(input logic bit_val, input logic second_half);
    logic [1:0] code;
    code = bit_val ? MANCH_ONE : MANCH_ZERO;
    return second_half ? code[0] : code[1];
  endfunction

endpackage

// File: rtl/eth_manchester_tx_timer.sv
// Half-bit timer for the Manchester transmitter: paces 16 half-bits per byte and
// flags the last clock of each half-bit and of each byte.
module manchester_half_timer #(
  parameter int HALF_BIT_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       half_tick,
  output logic       byte_tick,
  output logic [3:0] half_idx
);

  localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(HALF_BIT_CYCLES - 1);

  logic [CW-1:0] cycle_cnt;

  assign half_tick = en && (cycle_cnt == CYC_LAST);
  assign byte_tick = half_tick && (half_idx == 4'd15);

  // The 4-bit half index wraps to 0 on its own at the byte boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      half_idx  <= 4'd0;
    end else if (en) begin
      if (half_tick) begin
        cycle_cnt <= '0;
        half_idx  <= half_idx + 4'd1;
      end else begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_manchester_tx.sv
// Ethernet transmit framer: preamble, SFD, streamed payload and interframe gap,
// Manchester-encoded MSB first onto a registered, idle-high line.
module eth_manchester_tx
  import eth_tx_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 5,
  parameter int PREAMBLE_BYTES  = 7,
  parameter int IFG_CYCLES      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       eth_out,
  output logic       busy,
  output logic       underrun
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam logic [2:0]       PRE_LAST = 3'(PREAMBLE_BYTES - 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

  tx_state_e        state;
  tx_state_e        state_next;
  logic             half_tick;
  logic             byte_tick;
  logic [3:0]       half_idx;
  logic [3:0]       half_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
  logic [2:0]       pre_cnt;
  logic             last_q;
  logic [IFG_W-1:0] ifg_cnt;
  logic             timer_en;
  logic             pre_done;
  logic             ifg_done;
  logic             data_open;
  logic [2:0]       bit_sel;
  logic             line_next;

  assign timer_en  = (state == PREAMBLE) || (state == SFD) || (state == DATA);
  assign pre_done  = (pre_cnt == PRE_LAST);
  assign ifg_done  = (ifg_cnt == IFG_LAST);
  assign data_open = (state == SFD) || ((state == DATA) && !last_q);

  manchester_half_timer #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (timer_en),
    .half_tick(half_tick),
    .byte_tick(byte_tick),
    .half_idx (half_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (tx_valid) state_next = PREAMBLE;
      PREAMBLE: if (byte_tick && pre_done) state_next = SFD;
      SFD, DATA: begin
        if (byte_tick) begin
          if (data_open && tx_valid) state_next = DATA;
          else                       state_next = IFG;
        end
      end
      IFG:      if (ifg_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Handshake strobes exist only on the boundary of a byte that still expects a successor.
  always_comb begin
    tx_ready = 1'b0;
    underrun = 1'b0;
    busy     = (state != IDLE);
    if (!rst && byte_tick && data_open) begin
      tx_ready = tx_valid;
      underrun = !tx_valid;
    end
  end

  always_comb begin
    shift_next = shift_reg;
    unique case (state)
      IDLE:      if (tx_valid) shift_next = PREAMBLE_BYTE;
      PREAMBLE:  if (byte_tick && pre_done) shift_next = SFD_BYTE;
      SFD, DATA: if (tx_ready) shift_next = tx_data;
      default:   shift_next = shift_reg;
    endcase
  end

  // The line register is loaded with the level of the half-bit about to start,
  // so the first preamble half appears right after the request edge.
  always_comb begin
    half_next = half_tick ? half_idx + 4'd1 : half_idx;
    bit_sel   = 3'd7 - half_next[3:1];
    line_next = 1'b1;
    if ((state_next == PREAMBLE) || (state_next == SFD) || (state_next == DATA))
      line_next = manch_level(shift_next[bit_sel], half_next[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= 8'h00;
      pre_cnt   <= 3'd0;
      last_q    <= 1'b0;
      ifg_cnt   <= '0;
      eth_out   <= 1'b1;
    end else begin
      shift_reg <= shift_next;
      eth_out   <= line_next;

      if (state == IDLE)
        pre_cnt <= 3'd0;
      else if ((state == PREAMBLE) && byte_tick)
        pre_cnt <= pre_done ? 3'd0 : pre_cnt + 3'd1;

      if (tx_ready)
        last_q <= tx_last;
      else if (state == IDLE)
        last_q <= 1'b0;

      if (state == IFG)
        ifg_cnt <= ifg_done ? '0 : ifg_cnt + 1'b1;
      else
        ifg_cnt <= '0;
    end
  end

endmodule
